// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch queue: bus encodings, entry state and entry payload.
package fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ifq_state_e;

    typedef struct packed {
        ifq_state_e        state;
        logic [TAG_W-1:0]  tag;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   ir;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_tag_cam.sv
// Compares a returning memory tag against every waiting queue entry; one-hot hit vector out.
module ifq_tag_cam
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [DEPTH-1:0]            waiting,
    input  logic [TAG_W-1:0]            lookup,
    output logic [DEPTH-1:0]            hit
);

    // Tag 0 never matches: it encodes "no data this cycle".
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = waiting[i] && (tags[i] == lookup) && (lookup != '0);
        end
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues tagged loads, collects out-of-order returns,
// hands instructions to IF in program order, and flushes on redirect.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              if_ready,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_PC,
    output logic [XLEN-1:0]   if_NPC,
    output logic [XLEN-1:0]   if_IR,
    output logic [XLEN-1:0]   proc2Imem_addr,
    output logic [1:0]        proc2Imem_command,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [XLEN-1:0]   mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned NTAGS = 1 << TAG_W;

    ifq_entry_t        entries [DEPTH];
    logic [PTR_W-1:0]  head, tail, head_next;
    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   fetch_pc;
    logic [NTAGS-1:0]  stale, stale_flush;
    logic              valid_q;
    logic [XLEN-1:0]   pc_q, ir_q;

    logic                       issue, accept, pop, tag_present, any_hit;
    logic [DEPTH-1:0][TAG_W-1:0] cam_tags;
    logic [DEPTH-1:0]           cam_wait;
    logic [DEPTH-1:0]           hit;

    // Request/handshake decode for the current cycle.
    always_comb begin
        issue       = rst_n && (count < CNT_W'(DEPTH)) && !redirect_valid;
        accept      = issue && (mem2proc_response != '0);
        pop         = if_valid && if_ready;
        head_next   = pop ? head + PTR_W'(1) : head;
        tag_present = (mem2proc_tag != '0);
        any_hit     = |hit;
        for (int i = 0; i < DEPTH; i++) begin
            cam_tags[i] = entries[i].tag;
            cam_wait[i] = (entries[i].state == WAIT);
        end
    end

    // On redirect every in-flight tag becomes stale, except one returning right now.
    always_comb begin
        stale_flush = stale;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].state == WAIT) begin
                stale_flush[entries[i].tag] = 1'b1;
            end
        end
        if (tag_present) begin
            stale_flush[mem2proc_tag] = 1'b0;
        end
    end

    ifq_tag_cam #(.DEPTH(DEPTH)) u_cam (
        .tags    (cam_tags),
        .waiting (cam_wait),
        .lookup  (mem2proc_tag),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
            stale    <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            ir_q     <= '0;
        end else if (redirect_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].state <= FREE;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc;
            stale    <= stale_flush;
            valid_q  <= 1'b0;
        end else begin
            if (accept) begin
                entries[tail] <= '{state: WAIT, tag: mem2proc_response, pc: fetch_pc, ir: '0};
                tail          <= tail + PTR_W'(1);
                fetch_pc      <= fetch_pc + XLEN'(4);
            end
            if (pop) begin
                entries[head].state <= FREE;
                head                <= head_next;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (hit[i]) begin
                    entries[i].state <= DONE;
                    entries[i].ir    <= mem2proc_data;
                end
            end
            if (tag_present && !any_hit && stale[mem2proc_tag]) begin
                stale[mem2proc_tag] <= 1'b0;
            end
            count <= count + CNT_W'(accept) - CNT_W'(pop);
            // Output stage sees the entry state from before this edge: one cycle of latency.
            valid_q <= (entries[head_next].state == DONE);
            pc_q    <= entries[head_next].pc;
            ir_q    <= entries[head_next].ir;
        end
    end

    assign if_valid          = valid_q && !redirect_valid;
    assign if_PC             = pc_q;
    assign if_IR             = ir_q;
    assign if_NPC            = pc_q + XLEN'(4);
    assign proc2Imem_addr    = fetch_pc;
    assign proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for the prefetch queue with a small tagged-memory responder driven per cycle.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_PC, if_NPC, if_IR;
    logic [31:0] proc2Imem_addr;
    logic [1:0]  proc2Imem_command;
    logic [3:0]  mem2proc_response;
    logic [31:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          delay_q[$];
    logic [31:0] acc_addrs[$];
    logic [3:0]  next_tag;
    int          mem_delay;
    int          reject_cnt;
    int          cyc;
    int          tests;
    int          fails;

    fetch_prefetch_queue dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .if_ready          (if_ready),
        .if_valid          (if_valid),
        .if_PC             (if_PC),
        .if_NPC            (if_NPC),
        .if_IR             (if_IR),
        .proc2Imem_addr    (proc2Imem_addr),
        .proc2Imem_command (proc2Imem_command),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    always #5 clk = ~clk;

    // One clock: memory answers this cycle's request/returns, then edge, then settle at negedge.
    task automatic cycle();
        int idx;
        int d;
        #1;
        idx = -1;
        mem2proc_tag  = 4'd0;
        mem2proc_data = 32'd0;
        for (int i = 0; i < pend.size(); i++) begin
            if (idx < 0 && pend[i].due <= cyc) idx = i;
        end
        if (idx >= 0) begin
            mem2proc_tag  = pend[idx].tag;
            mem2proc_data = {16'hC0DE, pend[idx].addr[15:0]};
            pend.delete(idx);
        end
        mem2proc_response = 4'd0;
        if (proc2Imem_command == 2'd1) begin
            if (reject_cnt > 0) begin
                reject_cnt--;
            end else begin
                mem2proc_response = next_tag;
                d = (delay_q.size() > 0) ? delay_q.pop_front() : mem_delay;
                pend.push_back('{tag: next_tag, addr: proc2Imem_addr, due: cyc + d});
                acc_addrs.push_back(proc2Imem_addr);
                next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'd0;
        if_ready          = 1'b0;
        mem2proc_response = 4'd0;
        mem2proc_tag      = 4'd0;
        mem2proc_data     = 32'd0;
        pend.delete();
        delay_q.delete();
        acc_addrs.delete();
        next_tag   = 4'd1;
        mem_delay  = 2;
        reject_cnt = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;
        mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = 32'd0;
        #2;
        tests++;
        if (if_valid !== 1'b0 || proc2Imem_command !== 2'd0 || proc2Imem_addr !== 32'd0) begin
            $display("FAIL reset_outputs: valid=%b cmd=%0d addr=%h, want 0/0/0", if_valid, proc2Imem_command, proc2Imem_addr);
            fails++;
        end
        tests++;
        if (dut.stale !== 16'h0) begin
            $display("FAIL reset_stale: got %h want 0000", dut.stale);
            fails++;
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        if_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            tests++;
            if (k < 4) begin
                if (if_valid !== 1'b0) begin
                    $display("FAIL stream_early_valid cycle %0d: got %b want 0", k, if_valid);
                    fails++;
                end
            end else begin
                exp_pc = 32'(4 * (k - 4));
                if (if_valid !== 1'b1 || if_PC !== exp_pc || if_NPC !== exp_pc + 32'd4 ||
                    if_IR !== {16'hC0DE, exp_pc[15:0]}) begin
                    $display("FAIL stream_order cycle %0d: valid=%b pc=%h npc=%h ir=%h, want pc %h",
                             k, if_valid, if_PC, if_NPC, if_IR, exp_pc);
                    fails++;
                end
            end
        end
    endtask

    task automatic test_full_back_to_back();
        do_reset();
        repeat (8) cycle();
        tests++;
        if (acc_addrs.size() != 4 || acc_addrs[0] !== 32'h0 || acc_addrs[3] !== 32'hC) begin
            $display("FAIL full_issue_count: got %0d loads, want 4 (0..C)", acc_addrs.size());
            fails++;
        end
        tests++;
        if (proc2Imem_command !== 2'd0 || if_valid !== 1'b1 || if_PC !== 32'h0) begin
            $display("FAIL full_hold: cmd=%0d valid=%b pc=%h, want 0/1/0", proc2Imem_command, if_valid, if_PC);
            fails++;
        end
        if_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            tests++;
            if (if_valid !== 1'b1 || if_PC !== 32'(4 * k)) begin
                $display("FAIL back_to_back_pc %0d: valid=%b pc=%h want %h", k, if_valid, if_PC, 32'(4 * k));
                fails++;
            end
        end
        cycle();
        for (int w = 0; w < 6 && if_valid !== 1'b1; w++) cycle();
        tests++;
        if (if_valid !== 1'b1 || if_PC !== 32'h10) begin
            $display("FAIL wrap_refill: valid=%b pc=%h want 1/00000010", if_valid, if_PC);
            fails++;
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        if_ready = 1'b1;
        delay_q = '{4, 2, 4, 4};
        for (int k = 1; k <= 5; k++) begin
            cycle();
            tests++;
            if (if_valid !== 1'b0) begin
                $display("FAIL ooo_wait_head cycle %0d: got valid %b want 0", k, if_valid);
                fails++;
            end
        end
        cycle();
        tests++;
        if (if_valid !== 1'b1 || if_PC !== 32'h0) begin
            $display("FAIL ooo_first: valid=%b pc=%h want 1/0", if_valid, if_PC);
            fails++;
        end
        cycle();
        tests++;
        if (if_valid !== 1'b1 || if_PC !== 32'h4 || if_IR !== 32'hC0DE0004) begin
            $display("FAIL ooo_second: valid=%b pc=%h ir=%h want 1/4/C0DE0004", if_valid, if_PC, if_IR);
            fails++;
        end
    endtask

    task automatic test_reject();
        do_reset();
        reject_cnt = 3;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            tests++;
            if (proc2Imem_addr !== 32'h0 || proc2Imem_command !== 2'd1) begin
                $display("FAIL reject_hold %0d: addr=%h cmd=%0d want 0/1", k, proc2Imem_addr, proc2Imem_command);
                fails++;
            end
        end
        cycle();
        tests++;
        if (proc2Imem_addr !== 32'h4 || acc_addrs.size() != 1) begin
            $display("FAIL reject_accept: addr=%h accepts=%0d want 4/1", proc2Imem_addr, acc_addrs.size());
            fails++;
        end
        if_ready = 1'b1;
        for (int w = 0; w < 8 && if_valid !== 1'b1; w++) cycle();
        tests++;
        if (if_valid !== 1'b1 || if_PC !== 32'h0) begin
            $display("FAIL reject_first: valid=%b pc=%h want 1/0", if_valid, if_PC);
            fails++;
        end
        cycle();
        tests++;
        if (if_valid !== 1'b1 || if_PC !== 32'h4) begin
            $display("FAIL reject_no_dup: valid=%b pc=%h want 1/4", if_valid, if_PC);
            fails++;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        delay_q = '{2, 8, 8, 8};
        repeat (4) cycle();
        tests++;
        if (if_valid !== 1'b1 || if_PC !== 32'h0) begin
            $display("FAIL redir_pre: valid=%b pc=%h want 1/0", if_valid, if_PC);
            fails++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        tests++;
        if (if_valid !== 1'b0 || proc2Imem_command !== 2'd0) begin
            $display("FAIL redir_cycle: valid=%b cmd=%0d want 0/0", if_valid, proc2Imem_command);
            fails++;
        end
        cycle();
        redirect_valid = 1'b0;
        tests++;
        if (dut.stale !== 16'h001C || if_valid !== 1'b0) begin
            $display("FAIL redir_stale_set: stale=%h valid=%b want 001c/0", dut.stale, if_valid);
            fails++;
        end
        cycle();
        tests++;
        if (if_valid !== 1'b0 || proc2Imem_addr !== 32'h104) begin
            $display("FAIL redir_after: valid=%b addr=%h want 0/00000104", if_valid, proc2Imem_addr);
            fails++;
        end
        repeat (9) cycle();
        tests++;
        if (dut.stale !== 16'h0) begin
            $display("FAIL redir_stale_clear: got %h want 0000", dut.stale);
            fails++;
        end
        tests++;
        if (if_valid !== 1'b1 || if_PC !== 32'h100 || if_IR !== 32'hC0DE0100) begin
            $display("FAIL redir_new_pc: valid=%b pc=%h ir=%h want 1/100/C0DE0100", if_valid, if_PC, if_IR);
            fails++;
        end
        if_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            tests++;
            if (if_valid !== 1'b1 || if_PC !== 32'h100 + 32'(4 * k)) begin
                $display("FAIL redir_stream %0d: valid=%b pc=%h want %h", k, if_valid, if_PC, 32'h100 + 32'(4 * k));
                fails++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_new;
        do_reset();
        mem_delay = 6;
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        tests++;
        if (if_valid !== 1'b0 || proc2Imem_command !== 2'd0 || proc2Imem_addr !== 32'h0) begin
            $display("FAIL midreset_outputs: valid=%b cmd=%0d addr=%h want 0/0/0", if_valid, proc2Imem_command, proc2Imem_addr);
            fails++;
        end
        mem_delay = 2;
        cycle();
        rst_n = 1'b1;
        first_new = acc_addrs.size();
        #1;
        tests++;
        if (proc2Imem_command !== 2'd1 || proc2Imem_addr !== 32'h0) begin
            $display("FAIL midreset_restart: cmd=%0d addr=%h want 1/0", proc2Imem_command, proc2Imem_addr);
            fails++;
        end
        @(negedge clk);
        for (int w = 0; w < 12 && if_valid !== 1'b1; w++) cycle();
        tests++;
        if (if_valid !== 1'b1 || if_PC !== 32'h0 || if_IR !== 32'hC0DE0000 ||
            acc_addrs.size() <= first_new || acc_addrs[first_new] !== 32'h0) begin
            $display("FAIL midreset_first: valid=%b pc=%h ir=%h want 1/0/C0DE0000", if_valid, if_PC, if_IR);
            fails++;
        end
        tests++;
        if (dut.stale !== 16'h0) begin
            $display("FAIL midreset_stale: got %h want 0000", dut.stale);
            fails++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        next_tag   = 4'd1;
        mem_delay  = 2;
        reject_cnt = 0;
        test_reset();
        test_stream();
        test_full_back_to_back();
        test_out_of_order();
        test_reject();
        test_redirect();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
